// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_seq_pkg                                                                 |
// | State encoding and amplitude helpers shared by the PWM drive sequencer.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package pwm_seq_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } pwm_state_t;

    // Largest positive value of a signed amp_w-bit word.
    function automatic logic [31:0] amp_max(input int unsigned amp_w);
        return (32'd1 << (amp_w - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_seq_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_seq_ramp                                                                |
// | Amplitude register with step timer and saturating up/down stepping.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_seq_ramp #(
    parameter int AMP_W     = 16,
    parameter int STEP_CYC  = 256,
    parameter int STEP_SIZE = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             clr,
    input  logic             restart,
    input  logic             step_up,
    input  logic             step_down,
    input  logic [AMP_W-1:0] tgt_in,
    output logic [AMP_W-1:0] amp,
    output logic [AMP_W-1:0] tgt
);

    localparam int              c_TMR_W = $clog2(STEP_CYC + 1);
    localparam logic [AMP_W:0]  c_STEP  = (AMP_W+1)'(STEP_SIZE);

    logic [c_TMR_W-1:0] r_tmr;
    logic [AMP_W-1:0]   r_amp;
    logic [AMP_W-1:0]   r_tgt;
    logic               w_tick;
    logic [AMP_W:0]     w_sum;
    logic [AMP_W:0]     w_diff;
    logic [AMP_W-1:0]   w_up;
    logic [AMP_W-1:0]   w_dn;

    assign w_tick = (r_tmr == c_TMR_W'(STEP_CYC - 1));
    assign w_sum  = {1'b0, r_amp} + c_STEP;
    assign w_diff = {1'b0, r_amp} - c_STEP;
    // One extra bit catches overshoot above the target and borrow below zero.
    assign w_up   = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[AMP_W-1:0];
    assign w_dn   = w_diff[AMP_W] ? '0 : w_diff[AMP_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmr <= '0;
            r_amp <= '0;
            r_tgt <= '0;
        end else if (clr) begin
            r_tmr <= '0;
            r_amp <= '0;
        end else if (load) begin
            r_tmr <= '0;
            r_amp <= '0;
            r_tgt <= tgt_in;
        end else if (restart || !(step_up || step_down)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
            if (w_tick) begin
                r_amp <= step_up ? w_up : w_dn;
            end
        end
    end

    assign amp = r_amp;
    assign tgt = r_tgt;

endmodule
`default_nettype wire

// File: rtl/pwm_drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_drive_sequencer                                                         |
// | Precharge / soft-start / run / soft-stop / fault sequencer for the PWM      |
// | gate stage. Revision: 1.0                                                   |
// +----------------------------------------------------------------------------+
module pwm_drive_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int AMP_W          = 16,
    parameter int PRECHARGE_CYC  = 1000,
    parameter int STEP_CYC       = 256,
    parameter int STEP_SIZE      = 128,
    parameter int FAULT_HOLD_CYC = 10000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 fault_in,
    input  logic                 fault_clr,
    input  logic [AMP_W-1:0]     amp_target,
    output logic [AMP_W-1:0]     amp_scale,
    output logic                 gate_en,
    output logic                 lowside_on,
    output logic [c_STATE_W-1:0] state,
    output logic                 fault_latched,
    output logic                 ramp_done
);

    localparam int               c_PRE_W   = $clog2(PRECHARGE_CYC + 1);
    localparam int               c_HOLD_W  = $clog2(FAULT_HOLD_CYC + 1);
    localparam logic [AMP_W-1:0] c_AMP_MAX = AMP_W'(amp_max(AMP_W));

    pwm_state_t          r_state;
    pwm_state_t          w_next;
    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_gate_en;
    logic                r_lowside_on;
    logic                r_fault_latched;
    logic                r_ramp_done;
    logic                w_pre_done;
    logic                w_hold_done;
    logic                w_entry;
    logic                w_load;
    logic                w_clr;
    logic [AMP_W-1:0]    w_tgt_clamped;
    logic [AMP_W-1:0]    w_amp;
    logic [AMP_W-1:0]    w_tgt;

    assign w_tgt_clamped = (amp_target > c_AMP_MAX) ? c_AMP_MAX : amp_target;
    assign w_pre_done    = (r_pre_cnt == c_PRE_W'(PRECHARGE_CYC - 1));
    assign w_hold_done   = (r_hold_cnt == c_HOLD_W'(FAULT_HOLD_CYC));
    assign w_entry       = (w_next != r_state);
    assign w_load        = (r_state == ST_IDLE) && (w_next == ST_PRECHARGE);
    assign w_clr         = (w_next == ST_FAULT) || (w_next == ST_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop && !fault_in) w_next = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (fault_in)        w_next = ST_FAULT;
                else if (stop)       w_next = ST_IDLE;
                else if (w_pre_done) w_next = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (fault_in)            w_next = ST_FAULT;
                else if (stop)           w_next = ST_RAMP_DOWN;
                else if (w_amp == w_tgt) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (fault_in)            w_next = ST_FAULT;
                else if (stop || !start) w_next = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (fault_in)          w_next = ST_FAULT;
                else if (w_amp == '0)  w_next = ST_IDLE;
            end
            ST_FAULT: begin
                // A clear before the hold expires is dropped, not remembered.
                if (fault_clr && !fault_in && w_hold_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_pre_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_gate_en       <= 1'b0;
            r_lowside_on    <= 1'b0;
            r_fault_latched <= 1'b0;
            r_ramp_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pre_cnt  <= (w_entry || r_state != ST_PRECHARGE) ? '0 : r_pre_cnt + 1'b1;
            r_hold_cnt <= (w_entry || r_state != ST_FAULT) ? '0 :
                          (w_hold_done ? r_hold_cnt : r_hold_cnt + 1'b1);
            r_gate_en       <= (w_next == ST_RAMP_UP) || (w_next == ST_RUN) ||
                               (w_next == ST_RAMP_DOWN);
            r_lowside_on    <= (w_next == ST_PRECHARGE);
            r_fault_latched <= (w_next == ST_FAULT);
            r_ramp_done     <= ((r_state == ST_RAMP_UP)   && (w_next == ST_RUN)) ||
                               ((r_state == ST_RAMP_DOWN) && (w_next == ST_IDLE));
        end
    end

    pwm_seq_ramp #(
        .AMP_W     (AMP_W),
        .STEP_CYC  (STEP_CYC),
        .STEP_SIZE (STEP_SIZE)
    ) u_ramp (
        .clk       (clk),
        .resetn    (resetn),
        .load      (w_load),
        .clr       (w_clr),
        .restart   (w_entry),
        .step_up   (r_state == ST_RAMP_UP),
        .step_down (r_state == ST_RAMP_DOWN),
        .tgt_in    (w_tgt_clamped),
        .amp       (w_amp),
        .tgt       (w_tgt)
    );

    assign amp_scale     = w_amp;
    assign gate_en       = r_gate_en;
    assign lowside_on    = r_lowside_on;
    assign state         = r_state;
    assign fault_latched = r_fault_latched;
    assign ramp_done     = r_ramp_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_drive_sequencer                                                      |
// | Scoreboard bench: cycle model pushes expectations, monitor compares.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pwm_drive_sequencer;

    localparam int AMP_W = 16;
    localparam int PRE   = 10;
    localparam int STEP  = 4;
    localparam int SSZ   = 100;
    localparam int HOLD  = 20;
    localparam int AMAX  = (1 << (AMP_W - 1)) - 1;

    localparam int M_IDLE = 0, M_PRE = 1, M_RU = 2, M_RUN = 3, M_RD = 4, M_FAULT = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0, stop = 1'b0, fault_in = 1'b0, fault_clr = 1'b0;
    logic [AMP_W-1:0] amp_target = '0;
    logic [AMP_W-1:0] amp_scale;
    logic             gate_en, lowside_on, fault_latched, ramp_done;
    logic [2:0]       state;

    pwm_drive_sequencer #(
        .AMP_W(AMP_W), .PRECHARGE_CYC(PRE), .STEP_CYC(STEP),
        .STEP_SIZE(SSZ), .FAULT_HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .fault_in(fault_in), .fault_clr(fault_clr), .amp_target(amp_target),
        .amp_scale(amp_scale), .gate_en(gate_en), .lowside_on(lowside_on),
        .state(state), .fault_latched(fault_latched), .ramp_done(ramp_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [2:0]       st;
        logic [AMP_W-1:0] amp;
        logic             ge, ls, fl, rd;
    } exp_t;

    exp_t q[$];
    int   edge_no = 0;
    int   checks  = 0;
    int   errors  = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Reference model: mode, edges since mode entry, amplitude and target.
    int m_mode, m_age, m_amp, m_tgt;
    bit m_done;

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_amp = 0; m_tgt = 0; m_done = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit fi, input bit fc, input int tg);
        int nm, nage, namp;
        nm = m_mode; nage = m_age + 1; namp = m_amp;
        case (m_mode)
            M_IDLE: if (st && !sp && !fi) begin
                nm = M_PRE;
                m_tgt = (tg > AMAX) ? AMAX : tg;
            end
            M_PRE: begin
                if (fi) nm = M_FAULT;
                else if (sp) nm = M_IDLE;
                else if (nage >= PRE) nm = M_RU;
            end
            M_RU: begin
                if (fi) nm = M_FAULT;
                else if (sp) nm = M_RD;
                else if (m_amp == m_tgt) nm = M_RUN;
                else if (nage % STEP == 0) namp = (m_amp + SSZ > m_tgt) ? m_tgt : m_amp + SSZ;
            end
            M_RUN: begin
                if (fi) nm = M_FAULT;
                else if (sp || !st) nm = M_RD;
            end
            M_RD: begin
                if (fi) nm = M_FAULT;
                else if (m_amp == 0) nm = M_IDLE;
                else if (nage % STEP == 0) namp = (m_amp < SSZ) ? 0 : m_amp - SSZ;
            end
            default: if (fc && !fi && m_age >= HOLD) nm = M_IDLE;
        endcase
        m_done = (m_mode == M_RU && nm == M_RUN) || (m_mode == M_RD && nm == M_IDLE);
        if (nm != m_mode) begin
            nage = 0;
            if (nm == M_FAULT || nm == M_IDLE) namp = 0;
        end
        m_mode = nm; m_age = nage; m_amp = namp;
    endtask

    // Drive one cycle of inputs, push the expectation for the coming edge.
    task automatic tick(input bit st, input bit sp, input bit fi, input bit fc,
                        input logic [AMP_W-1:0] tg);
        exp_t e;
        start = st; stop = sp; fault_in = fi; fault_clr = fc; amp_target = tg;
        if (!resetn) model_reset();
        else model_step(st, sp, fi, fc, int'(tg));
        e.idx = edge_no + 1;
        e.st  = 3'(m_mode);
        e.amp = AMP_W'(m_amp);
        e.ge  = (m_mode == M_RU || m_mode == M_RUN || m_mode == M_RD);
        e.ls  = (m_mode == M_PRE);
        e.fl  = (m_mode == M_FAULT);
        e.rd  = m_done;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int mode, input bit st, input bit sp,
                             input logic [AMP_W-1:0] tg, input int budget, input string name);
        int n;
        n = budget;
        while (m_mode != mode && n > 0) begin
            tick(st, sp, 1'b0, 1'b0, tg);
            n--;
        end
        checks++;
        if (m_mode != mode) begin
            errors++;
            $display("FAIL timeout_%s: mode=%0d required mode=%0d within %0d cycles",
                     name, m_mode, mode, budget);
        end
    endtask

    // Monitor: compares every presented output sample against the queued expectation.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            while (q.size() > 0 && q[0].idx < edge_no) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL missed_sample: edge=%0d required sample edge=%0d", edge_no, e.idx);
            end
            if (q.size() > 0 && q[0].idx == edge_no) begin
                e = q.pop_front();
                checks++;
                if ({state, amp_scale, gate_en, lowside_on, fault_latched, ramp_done} !==
                    {e.st, e.amp, e.ge, e.ls, e.fl, e.rd}) begin
                    errors++;
                    $display("FAIL outputs@edge%0d: got st=%0d amp=%0d ge=%0b ls=%0b fl=%0b rd=%0b required st=%0d amp=%0d ge=%0b ls=%0b fl=%0b rd=%0b",
                             edge_no, state, amp_scale, gate_en, lowside_on, fault_latched, ramp_done,
                             e.st, e.amp, e.ge, e.ls, e.fl, e.rd);
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd350);
        resetn = 1'b1;

        // Soft-start to 350, hold in RUN with target changes, then soft-stop.
        run_until(M_RUN, 1'b1, 1'b0, 16'd350, 60, "ramp_up_350");
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(($urandom)));
        run_until(M_IDLE, 1'b0, 1'b0, 16'd0, 40, "ramp_down_350");
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Fault mid ramp-up; early clear dropped, late clear honoured.
        run_until(M_RU, 1'b1, 1'b0, 16'd350, 30, "reach_ramp_up");
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd350);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 16'd350);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd350);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd350);
        repeat (19) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd350);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd350);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // start+stop in IDLE, then stop during precharge.
        repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0, 16'd350);
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd350);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'd350);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Clamp of an over-range target, then a zero target.
        run_until(M_RUN, 1'b1, 1'b0, 16'hFFFF, 1500, "ramp_up_clamp");
        run_until(M_IDLE, 1'b1, 1'b1, 16'd0, 1500, "ramp_down_clamp");
        run_until(M_RUN, 1'b1, 1'b0, 16'd0, 30, "ramp_up_zero");
        run_until(M_IDLE, 1'b0, 1'b0, 16'd0, 10, "ramp_down_zero");

        // Asynchronous reset mid ramp-down at 150.
        run_until(M_RUN, 1'b1, 1'b0, 16'd350, 60, "ramp_up_for_reset");
        n = 100;
        while (!(m_mode == M_RD && m_amp == 150) && n > 0) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            n--;
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL timeout_rd150: mode=%0d amp=%0d required mode=4 amp=150", m_mode, m_amp);
        end
        #4;
        resetn = 1'b0;
        #1;
        checks++;
        if ({state, amp_scale, gate_en, lowside_on, fault_latched, ramp_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got st=%0d amp=%0d ge=%0b ls=%0b fl=%0b rd=%0b required all zero",
                     state, amp_scale, gate_en, lowside_on, fault_latched, ramp_done);
        end
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd350);
        resetn = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 16) != 0, ($urandom % 64) == 0, ($urandom % 128) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 4 == 0) ? 16'($urandom % 400) : 16'($urandom));
        end
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        #10;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
